// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, accumulator source selects and
// the control-unit state enum used by the sequencer, datapath and assembler.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_JC  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ASEL_ALU = 2'd0;
   localparam logic [1:0] ASEL_MEM = 2'd1;
   localparam logic [1:0] ASEL_IMM = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_FETCH_ADDR  = 3'd1,
      ST_FETCH_INSTR = 3'd2,
      ST_DECODE      = 3'd3,
      ST_EXEC1       = 3'd4,
      ST_EXEC2       = 3'd5,
      ST_HALT        = 3'd6
   } state_e;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer. Strobes are decoded combinationally
// from the registered state, so an asynchronous reset silences them at once.
module control_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       zero_flag,
   input  logic       carry_flag,
   input  logic       mem_ready,
   output logic       mar_load,
   output logic       mar_sel,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       a_load,
   output logic [1:0] a_sel,
   output logic       b_load,
   output logic       alu_sub,
   output logic       flags_load,
   output logic       out_load,
   output logic       halted,
   output logic [2:0] state_dbg
);

   state_e state_q;
   state_e state_d;
   state_e done_st;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_dbg = state_q;

   always_comb begin
      state_d    = state_q;
      done_st    = run ? ST_FETCH_ADDR : ST_IDLE;
      mar_load   = 1'b0;
      mar_sel    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      a_load     = 1'b0;
      a_sel      = ASEL_ALU;
      b_load     = 1'b0;
      alu_sub    = 1'b0;
      flags_load = 1'b0;
      out_load   = 1'b0;
      halted     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH_ADDR: begin
            mar_load = 1'b1;
            state_d  = ST_FETCH_INSTR;
         end
         ST_FETCH_INSTR: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH_INSTR;
            end
         end
         ST_DECODE: begin
            // Unassigned opcodes fall through to the NOP behaviour.
            case (opcode)
               OP_LDI: begin
                  a_load  = 1'b1;
                  a_sel   = ASEL_IMM;
                  state_d = done_st;
               end
               OP_JMP: begin
                  pc_load = 1'b1;
                  state_d = done_st;
               end
               OP_JZ: begin
                  pc_load = zero_flag;
                  state_d = done_st;
               end
               OP_JC: begin
                  pc_load = carry_flag;
                  state_d = done_st;
               end
               OP_OUT: begin
                  out_load = 1'b1;
                  state_d  = done_st;
               end
               OP_HLT: begin
                  state_d = ST_HALT;
               end
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  mar_load = 1'b1;
                  mar_sel  = 1'b1;
                  state_d  = ST_EXEC1;
               end
               default: begin
                  state_d = done_st;
               end
            endcase
         end
         ST_EXEC1: begin
            if (opcode == OP_STA) begin
               mem_write = 1'b1;
            end else begin
               mem_read = 1'b1;
            end
            if (mem_ready) begin
               case (opcode)
                  OP_LDA: begin
                     a_load  = 1'b1;
                     a_sel   = ASEL_MEM;
                     state_d = done_st;
                  end
                  OP_ADD, OP_SUB: begin
                     b_load  = 1'b1;
                     state_d = ST_EXEC2;
                  end
                  default: begin
                     state_d = done_st;
                  end
               endcase
            end else begin
               state_d = ST_EXEC1;
            end
         end
         ST_EXEC2: begin
            a_load     = 1'b1;
            a_sel      = ASEL_ALU;
            alu_sub    = (opcode == OP_SUB);
            flags_load = 1'b1;
            state_d    = done_st;
         end
         ST_HALT: begin
            halted  = 1'b1;
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instructions with random operands, flags,
// run levels and memory wait states are expanded into an expected per-cycle trace.
module tb_control_unit;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [3:0] opcode;
   logic       zero_flag;
   logic       carry_flag;
   logic       mem_ready;
   logic       mar_load, mar_sel, mem_read, mem_write, ir_load, pc_inc, pc_load;
   logic       a_load, b_load, alu_sub, flags_load, out_load, halted;
   logic [1:0] a_sel;
   logic [2:0] state_dbg;

   typedef struct packed {
      logic       mar_load;
      logic       mar_sel;
      logic       mem_read;
      logic       mem_write;
      logic       ir_load;
      logic       pc_inc;
      logic       pc_load;
      logic       a_load;
      logic [1:0] a_sel;
      logic       b_load;
      logic       alu_sub;
      logic       flags_load;
      logic       out_load;
      logic       halted;
      logic [2:0] st;
   } outs_t;

   typedef struct {
      logic       rdy;
      logic       run;
      logic [3:0] op;
      logic       zf;
      logic       cf;
      outs_t      exp;
   } cyc_t;

   cyc_t       q[$];
   int         tests = 0;
   int         fails = 0;
   logic [3:0] cur_op = 4'h0;
   logic       cur_zf = 1'b0;
   logic       cur_cf = 1'b0;

   control_unit dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
      .mar_load(mar_load), .mar_sel(mar_sel), .mem_read(mem_read),
      .mem_write(mem_write), .ir_load(ir_load), .pc_inc(pc_inc),
      .pc_load(pc_load), .a_load(a_load), .a_sel(a_sel), .b_load(b_load),
      .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
      .halted(halted), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic outs_t observe();
      outs_t o;
      o.mar_load = mar_load;   o.mar_sel = mar_sel;     o.mem_read = mem_read;
      o.mem_write = mem_write; o.ir_load = ir_load;     o.pc_inc = pc_inc;
      o.pc_load = pc_load;     o.a_load = a_load;       o.a_sel = a_sel;
      o.b_load = b_load;       o.alu_sub = alu_sub;     o.flags_load = flags_load;
      o.out_load = out_load;   o.halted = halted;       o.st = state_dbg;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input outs_t o, input logic rdy, input logic r);
      cyc_t c;
      c.rdy = rdy; c.run = r; c.op = cur_op; c.zf = cur_zf; c.cf = cur_cf; c.exp = o;
      q.push_back(c);
   endtask

   // n idle cycles with run low, then one idle cycle with run high to start fetching.
   task automatic add_idle(input int n);
      outs_t o;
      o = '0;
      o.st = ST_IDLE;
      for (int i = 0; i < n; i++) push(o, rb(), 1'b0);
      push(o, rb(), 1'b1);
   endtask

   task automatic add_halt(input int n);
      outs_t o;
      o = '0;
      o.st = ST_HALT;
      o.halted = 1'b1;
      for (int i = 0; i < n; i++) push(o, rb(), 1'b1);
   endtask

   // Expected trace of one instruction: address phase, fetch read (with waits),
   // decode, then optional memory phase (with waits) and ALU write-back phase.
   task automatic add_instr(input logic [3:0] op, input logic zf, input logic cf,
                            input int wf, input int we, input logic run_after);
      outs_t o;
      bit    is_mem;
      bit    is_alu;
      cur_op = op; cur_zf = zf; cur_cf = cf;
      is_mem = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
      is_alu = (op == OP_ADD) || (op == OP_SUB);

      o = '0; o.st = ST_FETCH_ADDR; o.mar_load = 1'b1;
      push(o, rb(), rb());
      o = '0; o.st = ST_FETCH_INSTR; o.mem_read = 1'b1;
      for (int i = 0; i < wf; i++) push(o, 1'b0, rb());
      o.ir_load = 1'b1; o.pc_inc = 1'b1;
      push(o, 1'b1, rb());

      o = '0; o.st = ST_DECODE;
      if (op == OP_HLT) begin
         push(o, rb(), rb());
         return;
      end
      if (is_mem) begin
         o.mar_load = 1'b1; o.mar_sel = 1'b1;
         push(o, rb(), rb());
      end else begin
         if (op == OP_LDI) begin o.a_load = 1'b1; o.a_sel = ASEL_IMM; end
         if (op == OP_JMP) o.pc_load = 1'b1;
         if (op == OP_JZ)  o.pc_load = zf;
         if (op == OP_JC)  o.pc_load = cf;
         if (op == OP_OUT) o.out_load = 1'b1;
         push(o, rb(), run_after);
         return;
      end

      o = '0; o.st = ST_EXEC1;
      if (op == OP_STA) o.mem_write = 1'b1;
      else o.mem_read = 1'b1;
      for (int i = 0; i < we; i++) push(o, 1'b0, rb());
      if (op == OP_LDA) begin o.a_load = 1'b1; o.a_sel = ASEL_MEM; end
      if (is_alu) o.b_load = 1'b1;
      push(o, 1'b1, is_alu ? rb() : run_after);
      if (is_alu) begin
         o = '0; o.st = ST_EXEC2;
         o.a_load = 1'b1; o.a_sel = ASEL_ALU; o.flags_load = 1'b1;
         o.alu_sub = (op == OP_SUB);
         push(o, rb(), run_after);
      end
   endtask

   task automatic check(input string tag, input outs_t obs, input outs_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Replay up to n queued cycles (n < 0: all), then discard anything left.
   task automatic run_queue(input int n);
      int   k;
      cyc_t c;
      logic both;
      k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         c = q.pop_front();
         @(negedge clk);
         run = c.run; mem_ready = c.rdy; opcode = c.op;
         zero_flag = c.zf; carry_flag = c.cf;
         #1;
         check($sformatf("cyc%0d_op%0h", k, c.op), observe(), c.exp);
         both = mem_read & mem_write;
         tests++;
         assert (both === 1'b0) else begin
            fails++;
            $error("FAIL rw_overlap observed=%b expected=0", both);
         end
         k++;
      end
      q.delete();
   endtask

   initial begin
      outs_t idle_o;
      logic  ra;
      idle_o = '0;
      idle_o.st = ST_IDLE;
      reset = 1'b1; run = 1'b1; opcode = OP_LDA; zero_flag = 1'b0;
      carry_flag = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("reset_state", observe(), idle_o);
      reset = 1'b0; run = 1'b0;

      add_idle(1);
      add_instr(OP_NOP, 1'b0, 1'b0, 0, 0, 1'b1);
      add_instr(OP_LDI, 1'b0, 1'b0, 0, 0, 1'b1);
      add_instr(OP_ADD, 1'b0, 1'b0, 0, 2, 1'b1);
      add_instr(OP_JZ,  1'b1, 1'b0, 0, 0, 1'b1);
      add_instr(OP_JZ,  1'b0, 1'b1, 0, 0, 1'b1);
      add_instr(OP_SUB, 1'b1, 1'b1, 1, 0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 3) != 0);
         add_instr(4'($urandom_range(0, 14)), rb(), rb(),
                   $urandom_range(0, 3), $urandom_range(0, 3), ra);
         if (!ra) add_idle($urandom_range(0, 2));
      end
      add_instr(OP_OUT, 1'b0, 1'b0, 0, 0, 1'b0);
      add_idle(2);
      run_queue(-1);

      // Abort an LDA while it is waiting on memory in EXEC1.
      add_instr(OP_LDA, 1'b0, 1'b0, 0, 3, 1'b1);
      run_queue(4);
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b1;
      #2 reset = 1'b1;
      #1 check("reset_mid_exec1", observe(), idle_o);
      @(posedge clk); #1;
      check("reset_held", observe(), idle_o);
      @(negedge clk);
      reset = 1'b0; run = 1'b0;
      #1 check("reset_released", observe(), idle_o);

      add_idle(1);
      add_instr(OP_STA, 1'b0, 1'b0, 0, 2, 1'b1);
      add_instr(OP_HLT, 1'b0, 1'b0, 1, 0, 1'b1);
      add_halt(10);
      run_queue(-1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
